// File: rtl/vram_painter.sv
// Rectangle-fill engine for the 100x75 RGB444 canvas RAM: clips a command to the canvas and
// emits one write per cycle. Define PAINTER_CLEAR_EN to add the cmd_clear full-canvas fill.
module vram_painter #(
  parameter int unsigned CANVAS_W = 100,
  parameter int unsigned CANVAS_H = 75
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x0,
  input  logic [6:0]  cmd_y0,
  input  logic [6:0]  cmd_x1,
  input  logic [6:0]  cmd_y1,
`ifdef PAINTER_CLEAR_EN
  input  logic        cmd_clear,
`endif
  input  logic [11:0] cmd_color,
  output logic        we,
  output logic [14:0] waddr,
  output logic [11:0] wdata,
  output logic        busy,
  output logic        done
);

  localparam logic [14:0] RowStep  = 15'(CANVAS_W);
  localparam logic [14:0] ParkAddr = 15'(CANVAS_W * CANVAS_H);
  localparam logic [6:0]  XMax     = 7'(CANVAS_W - 1);
  localparam logic [6:0]  YMax     = 7'(CANVAS_H - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  state_e      state_q, state_d;
  logic [6:0]  x0_q, y0_q, x1_q, y1_q, x0_d, y0_d, x1_d, y1_d;
  logic [6:0]  x_q, y_q, x_d, y_d;
  logic [11:0] color_q, color_d;
  logic [14:0] base_q, base_d;
  logic        we_q, we_d;
  logic [14:0] waddr_q, waddr_d;
  logic [11:0] wdata_q, wdata_d;

  logic [6:0]  lx0, ly0, lx1, ly1;
  logic [6:0]  x1c, y1c;
  logic        empty;
  logic [14:0] row0;

  // Command fields as latched; a clear command substitutes the full canvas.
  always_comb begin
    lx0 = cmd_x0;
    ly0 = cmd_y0;
    lx1 = cmd_x1;
    ly1 = cmd_y1;
`ifdef PAINTER_CLEAR_EN
    if (cmd_clear) begin
      lx0 = '0;
      ly0 = '0;
      lx1 = XMax;
      ly1 = YMax;
    end
`endif
  end

  assign x1c   = (x1_q > XMax) ? XMax : x1_q;
  assign y1c   = (y1_q > YMax) ? YMax : y1_q;
  assign empty = (x0_q > x1c) || (y0_q > y1c);
  assign row0  = 15'(y0_q) * RowStep;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= ParkAddr;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      base_q  <= base_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // x_q/y_q/base_q always describe the pixel currently on the write port.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    base_d  = base_q;
    we_d    = 1'b0;
    waddr_d = ParkAddr;
    wdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          x0_d    = lx0;
          y0_d    = ly0;
          x1_d    = lx1;
          y1_d    = ly1;
          color_d = cmd_color;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (empty) begin
          state_d = StDone;
        end else begin
          x_d     = x0_q;
          y_d     = y0_q;
          base_d  = row0;
          we_d    = 1'b1;
          waddr_d = row0 + 15'(x0_q);
          wdata_d = color_q;
          state_d = StFill;
        end
      end
      StFill: begin
        if (x_q != x1c) begin
          x_d     = x_q + 7'd1;
          we_d    = 1'b1;
          waddr_d = base_q + 15'(x_q) + 15'd1;
          wdata_d = color_q;
        end else if (y_q != y1c) begin
          x_d     = x0_q;
          y_d     = y_q + 7'd1;
          base_d  = base_q + RowStep;
          we_d    = 1'b1;
          waddr_d = base_q + RowStep + 15'(x0_q);
          wdata_d = color_q;
        end else begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_vram_painter.sv
// Directed self-checking bench for vram_painter: reset, fills, clipping, empty commands,
// busy-ignore, mid-fill reset and (when PAINTER_CLEAR_EN is defined) the clear command.
module tb_vram_painter;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
`ifdef PAINTER_CLEAR_EN
  logic        cmd_clear = 1'b0;
`endif
  logic        we;
  logic [14:0] waddr;
  logic [11:0] wdata;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  vram_painter dut (
    .pclk      (pclk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
`ifdef PAINTER_CLEAR_EN
    .cmd_clear (cmd_clear),
`endif
    .cmd_color (cmd_color),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Presents a command while idle; returns during cycle N+1 (acceptance at edge N).
  task automatic send(input logic [6:0] x0, input logic [6:0] y0, input logic [6:0] x1,
                      input logic [6:0] y1, input logic [11:0] color);
    check("ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_x1    = x1;
    cmd_y1    = y1;
    cmd_color = color;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int exp_a [6];
    int writes, errs, done_cyc, cyc;
    exp_a = '{302, 303, 304, 402, 403, 404};

    // Reset
    repeat (3) tick();
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", {17'd0, waddr}, 32'd7500);
    check("rst_wdata", {20'd0, wdata}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();

    // Rectangle (2,3)-(4,4)
    send(7'd2, 7'd3, 7'd4, 7'd4, 12'hF00);
    check("rect_setup_busy", {31'd0, busy}, 32'd1);
    check("rect_setup_ready", {31'd0, cmd_ready}, 32'd0);
    check("rect_setup_we", {31'd0, we}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rect_we", {31'd0, we}, 32'd1);
      check("rect_waddr", {17'd0, waddr}, exp_a[k]);
      check("rect_wdata", {20'd0, wdata}, 32'hF00);
    end
    tick();
    check("rect_done", {31'd0, done}, 32'd1);
    check("rect_done_we", {31'd0, we}, 32'd0);
    check("rect_park", {17'd0, waddr}, 32'd7500);
    check("rect_park_wdata", {20'd0, wdata}, 32'd0);
    tick();
    check("rect_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("rect_done_clear", {31'd0, done}, 32'd0);

    // Clipping (95,70)-(120,80)
    send(7'd95, 7'd70, 7'd120, 7'd80, 12'h0F0);
    for (int k = 0; k < 25; k++) begin
      tick();
      check("clip_we", {31'd0, we}, 32'd1);
      check("clip_waddr", {17'd0, waddr}, (70 + k / 5) * 100 + 95 + k % 5);
    end
    tick();
    check("clip_done", {31'd0, done}, 32'd1);
    check("clip_done_we", {31'd0, we}, 32'd0);
    tick();

    // Reversed corners, then x0 beyond the canvas
    send(7'd5, 7'd0, 7'd3, 7'd0, 12'h777);
    check("rev_setup_we", {31'd0, we}, 32'd0);
    tick();
    check("rev_done", {31'd0, done}, 32'd1);
    check("rev_we", {31'd0, we}, 32'd0);
    tick();
    send(7'd100, 7'd0, 7'd120, 7'd5, 12'h777);
    check("x0oob_setup_we", {31'd0, we}, 32'd0);
    tick();
    check("x0oob_done", {31'd0, done}, 32'd1);
    check("x0oob_we", {31'd0, we}, 32'd0);
    tick();

    // Full fill with a competing command held valid from cycle N+4
    send(7'd0, 7'd0, 7'd99, 7'd74, 12'hABC);
    writes = 0;
    errs = 0;
    done_cyc = -1;
    cyc = 1;
    while (cyc < 8000 && done_cyc < 0) begin
      tick();
      cyc++;
      if (cyc == 4) begin
        cmd_x0    = 7'd0;
        cmd_y0    = 7'd0;
        cmd_x1    = 7'd0;
        cmd_y1    = 7'd0;
        cmd_color = 12'h123;
        cmd_valid = 1'b1;
      end
      if (done) done_cyc = cyc;
      else if (we) begin
        if (waddr != 15'(writes) || wdata != 12'hABC || cmd_ready) errs++;
        writes++;
      end
    end
    check("full_writes", writes, 32'd7500);
    check("full_seq_errs", errs, 32'd0);
    check("full_done_cycle", done_cyc, 32'd7502);
    tick();
    check("queued_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("queued_accepted", {31'd0, busy}, 32'd1);
    tick();
    check("queued_we", {31'd0, we}, 32'd1);
    check("queued_waddr", {17'd0, waddr}, 32'd0);
    check("queued_wdata", {20'd0, wdata}, 32'h123);
    tick();
    check("queued_done", {31'd0, done}, 32'd1);
    tick();

    // Reset mid-fill
    send(7'd0, 7'd0, 7'd99, 7'd74, 12'h555);
    repeat (51) tick();
    check("abort_pre_we", {31'd0, we}, 32'd1);
    rst = 1'b0;
    tick();
    check("abort_we", {31'd0, we}, 32'd0);
    check("abort_waddr", {17'd0, waddr}, 32'd7500);
    check("abort_wdata", {20'd0, wdata}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    errs = 0;
    repeat (5) begin
      tick();
      if (we || !cmd_ready) errs++;
    end
    check("abort_quiet", errs, 32'd0);

`ifdef PAINTER_CLEAR_EN
    cmd_clear = 1'b1;
    send(7'd5, 7'd5, 7'd6, 7'd6, 12'h00F);
    cmd_clear = 1'b0;
    writes = 0;
    errs = 0;
    done_cyc = -1;
    cyc = 1;
    while (cyc < 8000 && done_cyc < 0) begin
      tick();
      cyc++;
      if (done) done_cyc = cyc;
      else if (we) begin
        if (waddr != 15'(writes) || wdata != 12'h00F) errs++;
        writes++;
      end
    end
    check("clear_writes", writes, 32'd7500);
    check("clear_seq_errs", errs, 32'd0);
    check("clear_done_cycle", done_cyc, 32'd7502);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
